// File: rtl/uart_rx_sipo.sv
// -----------------------------------------------------------------------------
// uart_rx_sipo
//   Serial-in/parallel-out UART receiver for 11-bit frames:
//     start(0), data[7:0] LSB first, parity, stop(1).
//   Runs on an OS-times oversampled baud clock and samples every bit at its
//   centre, timed from the edge that first sees the synchronised line low.
//
// Parameters
//   OS          baud_clk cycles per bit (even, >= 4)
//   PARITY_ODD  0 = even parity (bit = ^data), 1 = odd parity (bit = ~^data)
//
// Ports
//   baud_clk     in   oversample clock, all logic on its rising edge
//   reset        in   synchronous, active-high
//   data_rx      in   serial line, asynchronous to baud_clk, idles high
//   data_out     out  [7:0] last received byte
//   data_valid   out  one-cycle pulse when data_out/parity_err/frame_err update
//   parity_err   out  parity mismatch in the last frame
//   frame_err    out  stop bit sampled low in the last frame
//   active_flag  out  high while a frame is in progress (START..STOP)
// -----------------------------------------------------------------------------
module uart_rx_sipo #(
  parameter int OS         = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       baud_clk,
  input  logic       reset,
  input  logic       data_rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       active_flag
);

  localparam int            CW       = (OS > 1) ? $clog2(OS) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(OS / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state, state_d;
  logic          sync1, rx_s;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;
  logic          rx_parity, rx_parity_d;
  logic          load_out;

  // Two-flop synchronizer. Both stages reset to the idle level so that a
  // reset release never looks like a start bit on its own.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours, exactly like hardware.
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= data_rx;
      rx_s  <= sync1;
    end
  end

  // Next-state and datapath decisions. The edge that first sees rx_s low in
  // IDLE starts the frame; START waits half a bit to reach the start-bit
  // centre, after which every bit is a full OS cycles apart.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d     = state;
    cnt_d       = cnt;
    bit_idx_d   = bit_idx;
    shreg_d     = shreg;
    rx_parity_d = rx_parity;
    load_out    = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end

      START: begin
        if (cnt == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            // Line went back high before the start-bit centre: glitch.
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_d     = '0;
          shreg_d   = {rx_s, shreg[7:1]};  // LSB arrives first, ends at bit 0
          bit_idx_d = bit_idx + 1'b1;
          if (bit_idx == 3'd7) state_d = PARITY;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      PARITY: begin
        if (cnt == CNT_LAST) begin
          cnt_d       = '0;
          rx_parity_d = rx_s;
          state_d     = STOP;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_d    = '0;
          load_out = 1'b1;
          // Returning to IDLE at the stop centre leaves half a bit to catch
          // a back-to-back start; a low stop means a break, so wait it out.
          state_d  = rx_s ? IDLE : WAIT_HIGH;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end

      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      rx_parity  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bit_idx    <= bit_idx_d;
      shreg      <= shreg_d;
      rx_parity  <= rx_parity_d;
      data_valid <= load_out;
      if (load_out) begin
        data_out   <= shreg;
        parity_err <= rx_parity ^ (^shreg) ^ PARITY_ODD;
        frame_err  <= ~rx_s;
      end
    end
  end

  always_comb begin
    active_flag = state inside {START, DATA, PARITY, STOP};
  end

endmodule

// File: doc/uart_rx_sipo.md
Name: uart_rx_sipo

Overview:
- Serial-in/parallel-out UART receiver. It is the consumer stage for the TX shift-out block's line output.
- Accepts the same 11-bit frame the TX side emits: start 0, data[7:0] LSB first, parity, stop 1.
- Runs on an oversampled baud clock. Samples each bit at its centre and presents the byte, parity error and framing error to the host-side logic.

Parameters:
- OS, 16, oversampling ratio: baud_clk cycles per bit; even, >= 4.
- PARITY_ODD, 0, 0 = even parity (parity bit = ^data), 1 = odd parity (parity bit = ~^data).

Ports:
- baud_clk  input  1  oversample clock, OS x bit rate; all logic on its rising edge.
- reset  input  1  synchronous, active-high.
- data_rx  input  1  serial line, asynchronous to baud_clk, idles high.
- data_out  output  8  last received byte.
- data_valid  output  1  one-cycle pulse when data_out, parity_err and frame_err update.
- parity_err  output  1  received parity mismatched for the last frame.
- frame_err  output  1  stop bit sampled 0 in the last frame.
- active_flag  output  1  high while a frame is being received (states START..STOP).

Behaviour:
- Sync: 2-flop synchronizer on data_rx producing rx_s; both flops reset to 1. All decisions use rx_s only.
- Counters:
  - cnt, $clog2(OS) bits, counts baud_clk cycles within a bit.
  - bit_idx, 3 bits, data bit index.
  - shreg, 8 bits: each data sample shifts right, with the new bit entering at the MSB.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE: at an edge with rx_s==0, go to START with cnt=0. Call this edge E0.
  - START: cnt increments each cycle. At cnt==OS/2-1 (edge E0+OS/2), sample rx_s.
    - Sample 0: go to DATA, cnt=0, bit_idx=0.
    - Sample 1: false start, back to IDLE. No flags or outputs change.
  - DATA: at cnt==OS-1, sample into shreg, cnt=0, bit_idx+1. After bit_idx==7 is sampled, go to PARITY. Data bit k is sampled at E0+OS/2+(k+1)*OS.
  - PARITY: at cnt==OS-1, capture the parity bit (edge E0+OS/2+9*OS), cnt=0, go to STOP.
  - STOP: at cnt==OS-1 (edge E0+OS/2+10*OS), in one edge:
    - Register data_out=shreg.
    - Register parity_err = rx_parity ^ (^shreg) ^ PARITY_ODD.
    - Register frame_err = ~rx_s.
    - Set data_valid=1.
    - Next state: IDLE if rx_s==1, else WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. This stops a held-low line (break) from retriggering a start.
- data_valid:
  - High for exactly one cycle, the cycle after the STOP sampling edge.
  - Also asserted for frames with errors; data_out is still updated in that case.
- Output holding: data_out, parity_err and frame_err hold their values until the next data_valid.
- active_flag: 1 in START, DATA, PARITY and STOP; 0 in IDLE and WAIT_HIGH.
- Latency: first possible start detection after data_rx falls is 2-3 edges (synchronizer). data_valid rises OS/2+10*OS+1 edges after E0 (169 at OS=16).
- Back-to-back frames: the next start bit may follow the stop bit with no idle gap. IDLE is re-entered exactly at the stop centre, leaving OS/2 cycles for the next falling edge to be detected.
- Reset values:
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, active_flag=0.
  - state=IDLE, cnt=0, bit_idx=0, shreg=0, sync flops=1.
- Reset mid-frame: the frame is abandoned with no data_valid, and all outputs return to their reset values on the next edge.
- Reset held with the line low: after release, IDLE sees rx_s==0 once the sync flops fill. The resulting frame completes with frame_err=1, which is acceptable.
- A glitch on the line shorter than OS/2 cycles in IDLE is rejected as a false start.

Test Plan:
- Byte 0xA5, correct even parity (0), stop 1, OS=16 -> data_valid a single pulse 169 edges after E0; data_out=0xA5, parity_err=0, frame_err=0. active_flag high for exactly 168 cycles.
- Byte 0x3C sent with parity bit 1 (wrong for even parity) -> data_out=0x3C, parity_err=1. Repeat with PARITY_ODD=1 -> parity_err=0.
- Byte 0x00, stop bit 0, line then held low for 40 bit-times -> one data_valid with frame_err=1, FSM in WAIT_HIGH. No further data_valid until the line returns high and a new frame is sent.
- Line low pulse of 5 cycles in IDLE -> no transition out of START to DATA, no data_valid, active_flag high for at most OS/2 cycles.
- Two frames 0x55 then 0xFF back-to-back (no idle gap) -> two data_valid pulses exactly 11*OS=176 cycles apart, with the correct data and no errors.
- Reset asserted during DATA bit 4 of 0x81 -> all outputs 0 next edge, no data_valid. A following clean frame 0x81 is received correctly.
